// File: rtl/sram_pkg.sv
// Shared SRAM request-port definitions: data/address widths and the
// one-hot state encoding used by the stream reader.
package sram_pkg;
  localparam int SRAM_ADDR_W = 21;
  localparam int SRAM_DATA_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_data_t;

  typedef enum logic [5:0] {
    S_IDLE       = 6'b000001,
    S_ISSUE      = 6'b000010,
    S_WAIT_ACK   = 6'b000100,
    S_WAIT_DATA  = 6'b001000,
    S_DRAIN      = 6'b010000,
    S_ABORT_WAIT = 6'b100000
  } rd_state_e;

  // Bit 20 is the chip select, so a plain modulo-2^21 increment crosses chips.
  function automatic sram_addr_t addr_inc(input sram_addr_t a);
    return a + sram_addr_t'(1);
  endfunction
endpackage

// File: rtl/sram_stream_fifo.sv
// Small synchronous FIFO buffering SRAM read words toward the stream port.
// DEPTH must be a power of two; flush empties it in one cycle.
module sram_stream_fifo
  import sram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  sram_data_t             din,
  output sram_data_t             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  sram_data_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  // Gate the head word so an empty FIFO presents zero data.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/sram_stream_reader.sv
// Read-side initiator: issues one-at-a-time SRAM reads and streams the words out.
// Optional busy timeout enabled by defining SRAM_STREAM_TIMEOUT_EN.
module sram_stream_reader
  import sram_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SRAM_ADDR_W-1:0] start_addr,
  input  logic [SRAM_ADDR_W-1:0] length,
  input  logic                   abort,
  output logic                   active,
  output logic                   done,
  output logic                   error,
  output logic [SRAM_DATA_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [SRAM_ADDR_W-1:0] mem_addr,
  output logic                   mem_re,
  output logic                   mem_wr,
  input  logic                   mem_busy,
  input  logic [SRAM_DATA_W-1:0] mem_data
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  rd_state_e  state_q;
  sram_addr_t cur_addr_q, remaining_q;
  logic       mem_re_q, done_q, error_q;
  logic [CW-1:0] fifo_count, count_after;
  logic       fifo_empty, fifo_full, push, pop, flush, room, in_wait, capture, tmo_fire;
  logic [TMO_W-1:0] tmo_cnt;

  assign in_wait = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DATA);
  assign capture = (state_q == S_WAIT_DATA) && !mem_busy && !abort;
  assign push    = capture;
  assign pop     = !fifo_empty && m_ready;
  // Room is judged on the occupancy after this cycle's push/pop.
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  assign room        = count_after < CW'(FIFO_DEPTH);
  assign flush = (abort && state_q != S_ABORT_WAIT)
              || (state_q == S_ABORT_WAIT && !mem_busy)
              || tmo_fire;

`ifdef SRAM_STREAM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  logic [TMO_W-1:0] tmo_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || !in_wait || capture) tmo_cnt_q <= '0;
    else                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end
  assign tmo_cnt = tmo_cnt_q;
`else
  localparam bit TMO_EN = 1'b0;
  assign tmo_cnt = '0;
`endif
  assign tmo_fire = TMO_EN && in_wait && !abort
                 && !(state_q == S_WAIT_DATA && !mem_busy)
                 && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  sram_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (mem_data),
    .dout  (m_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_re_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_re_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: if (!abort && start) begin
          cur_addr_q  <= start_addr;
          remaining_q <= length;
          error_q     <= 1'b0;
          if (length == '0) state_q <= S_DRAIN;
          else if (room) begin
            mem_re_q <= 1'b1;
            state_q  <= S_WAIT_ACK;
          end else state_q <= S_ISSUE;
        end
        S_ISSUE: if (abort) state_q <= S_IDLE;
          else if (room) begin
            mem_re_q <= 1'b1;
            state_q  <= S_WAIT_ACK;
          end
        S_WAIT_ACK: if (abort) state_q <= S_ABORT_WAIT;
          else if (tmo_fire) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (mem_busy) state_q <= S_WAIT_DATA;
        S_WAIT_DATA: if (abort) state_q <= S_ABORT_WAIT;
          else if (!mem_busy) begin
            cur_addr_q  <= addr_inc(cur_addr_q);
            remaining_q <= remaining_q - sram_addr_t'(1);
            if (remaining_q == sram_addr_t'(1)) state_q <= S_DRAIN;
            else if (room) begin
              mem_re_q <= 1'b1;
              state_q  <= S_WAIT_ACK;
            end else state_q <= S_ISSUE;
          end else if (tmo_fire) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end
        S_DRAIN: if (abort) state_q <= S_IDLE;
          else if (fifo_empty) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        S_ABORT_WAIT: if (!mem_busy) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign active   = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign m_valid  = !fifo_empty;
  assign mem_addr = cur_addr_q;
  assign mem_re   = mem_re_q;
  assign mem_wr   = 1'b0;
endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: vector table, corner sequences
// and randomized transfers against an address/data reference model.
module tb_sram_stream_reader;
  logic        clk, rst, start, abort, active, done, error;
  logic [20:0] start_addr, length, mem_addr;
  logic [15:0] m_data, mem_data;
  logic        m_valid, m_ready, mem_re, mem_wr, mem_busy;

  int checks = 0, failures = 0;
  int ack_lat = 0, busy_len = 3, ctl_phase = 0, ctl_left = 0;
  bit hold_busy = 0;
  logic [20:0] ctl_addr = '0;
  logic [20:0] req_q[$];
  logic [15:0] got_q[$];
  int done_cnt = 0, proto_bad = 0, rdy_mode = 3, rdy_hold = 0;
  bit stall_prev = 0;
  logic [15:0] stall_data = '0;

  sram_stream_reader #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .abort(abort), .active(active), .done(done), .error(error),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr),
    .mem_busy(mem_busy), .mem_data(mem_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mdata(input logic [20:0] a);
    return a[15:0] ^ {a[20:16], 11'h5A3};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Controller model: busy after ack_lat cycles, for busy_len cycles, data on fall.
  initial begin
    mem_busy = 0;
    mem_data = 0;
    forever begin
      @(posedge clk); #2;
      if (mem_re && ctl_phase != 0) proto_bad++;
      if (ctl_phase != 0 && mem_addr !== ctl_addr) proto_bad++;
      if (mem_wr !== 1'b0) proto_bad++;
      case (ctl_phase)
        0: if (mem_re) begin
          ctl_addr = mem_addr;
          req_q.push_back(mem_addr);
          if (ack_lat == 0) begin mem_busy = 1; ctl_left = busy_len; ctl_phase = 2; end
          else begin ctl_left = ack_lat; ctl_phase = 1; end
        end
        1: begin
          ctl_left--;
          if (ctl_left == 0) begin mem_busy = 1; ctl_left = busy_len; ctl_phase = 2; end
        end
        default: begin
          mem_data = 16'($urandom);
          if (!hold_busy) ctl_left--;
          if (ctl_left <= 0) begin mem_busy = 0; mem_data = mdata(ctl_addr); ctl_phase = 0; end
        end
      endcase
    end
  end

  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk); #3;
      case (rdy_mode)
        0: m_ready = 1;
        1: m_ready = 1'($urandom % 2);
        2: if (rdy_hold > 0) begin m_ready = 0; rdy_hold--; end else m_ready = 1;
        default: m_ready = 0;
      endcase
    end
  end

  // Stream monitor: collects words, counts done pulses, checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (stall_prev && (!m_valid || m_data !== stall_data)) proto_bad++;
      stall_prev = m_valid && !m_ready && !abort;
      stall_data = m_data;
    end
  end

  task automatic clear_logs();
    req_q.delete();
    got_q.delete();
    done_cnt = 0;
    proto_bad = 0;
  endtask

  task automatic pulse_start(input logic [20:0] a, input logic [20:0] n);
    @(posedge clk); #1;
    start = 1; start_addr = a; length = n;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input logic [20:0] a, input int n);
    longint ea;
    check({tag, "_nreq"}, req_q.size(), n);
    check({tag, "_nwords"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      ea = (longint'(a) + i) % 2097152;
      if (i < req_q.size()) check($sformatf("%s_addr%0d", tag, i), req_q[i], ea);
      if (i < got_q.size()) check($sformatf("%s_data%0d", tag, i), got_q[i], mdata(21'(ea)));
    end
    check({tag, "_protocol"}, proto_bad, 0);
  endtask

  task automatic run_xfer(input string tag, input logic [20:0] a, input logic [20:0] n,
                          input int rmode, input int blen, input int alat,
                          input logic [20:0] exp_last);
    clear_logs();
    busy_len = blen; ack_lat = alat; rdy_mode = rmode; rdy_hold = 25;
    pulse_start(a, n);
    wait_done();
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_idle"}, active, 0);
    check({tag, "_last_addr"}, (req_q.size() > 0) ? req_q[req_q.size()-1] : 21'h1FFFFF, exp_last);
    check_stream(tag, a, int'(n));
  endtask

  typedef struct {
    logic [20:0] addr;
    logic [20:0] len;
    int          rmode;
    int          blen;
    int          alat;
    logic [20:0] exp_last;
  } vec_t;

  initial begin
    vec_t vt[5];
    int n;
    logic [20:0] ra, rn;
    vt[0] = '{21'h000010, 21'd3, 0, 3, 0, 21'h000012};
    vt[1] = '{21'h0FFFFF, 21'd2, 0, 2, 1, 21'h100000};
    vt[2] = '{21'h1FFFFF, 21'd2, 1, 1, 0, 21'h000000};
    vt[3] = '{21'h000100, 21'd6, 2, 2, 2, 21'h000105};
    vt[4] = '{21'h0FFFFD, 21'd5, 1, 4, 1, 21'h100001};

    rst = 1; start = 0; start_addr = 0; length = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_outputs", {active, done, error, m_valid, mem_re, mem_wr, mem_addr, m_data}, 64'd0);

    // Request goes out the cycle after start.
    clear_logs(); busy_len = 1; ack_lat = 0; rdy_mode = 0;
    pulse_start(21'h00002A, 21'd1);
    @(negedge clk);
    check("start_active", active, 1);
    check("start_mem_re", mem_re, 1);
    check("start_mem_addr", mem_addr, 21'h00002A);
    wait_done();
    check("start_done", done_cnt, 1);
    check_stream("single", 21'h00002A, 1);

    for (int i = 0; i < 5; i++)
      run_xfer($sformatf("vec%0d", i), vt[i].addr, vt[i].len, vt[i].rmode,
               vt[i].blen, vt[i].alat, vt[i].exp_last);

    // Zero length: no request, done two cycles after start.
    clear_logs();
    pulse_start(21'h000055, 21'd0);
    @(negedge clk);
    check("zero_done_early", done, 0);
    check("zero_active", active, 1);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_idle", active, 0);
    repeat (5) @(negedge clk);
    check("zero_nreq", req_q.size(), 0);
    check("zero_done_cnt", done_cnt, 1);

    // Backpressure: exactly FIFO_DEPTH requests, then everything after release.
    clear_logs(); busy_len = 3; ack_lat = 0; rdy_mode = 3;
    pulse_start(21'h000300, 21'd8);
    repeat (60) @(negedge clk);
    check("bp_stall_nreq", req_q.size(), 4);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, mdata(21'h000300));
    rdy_mode = 0;
    wait_done();
    check("bp_done", done_cnt, 1);
    check_stream("bp", 21'h000300, 8);

    // Abort during WAIT_DATA of the second request.
    clear_logs(); busy_len = 6; ack_lat = 0; rdy_mode = 3;
    pulse_start(21'h000400, 21'd4);
    n = 0;
    while (req_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
    check("abort_second_req", req_q.size(), 2);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    check("abort_flush", m_valid, 0);
    n = 0;
    while (active && n < 50) begin n++; @(negedge clk); end
    check("abort_wait_cycles", n, 5);
    repeat (20) @(negedge clk);
    check("abort_nreq", req_q.size(), 2);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_words", got_q.size(), 0);
    check("abort_valid", m_valid, 0);

    // Abort and start together: start is dropped.
    @(posedge clk); #1 start = 1; abort = 1; start_addr = 21'h700; length = 21'd2;
    @(posedge clk); #1 start = 0; abort = 0;
    @(negedge clk);
    check("abort_start_active", active, 0);
    check("abort_start_mem_re", mem_re, 0);

    // Controller stuck busy.
    clear_logs(); busy_len = 2; ack_lat = 0; hold_busy = 1; rdy_mode = 0;
    pulse_start(21'h000500, 21'd3);
`ifdef SRAM_STREAM_TIMEOUT_EN
    n = 0;
    while (!error && n < 40) begin @(negedge clk); n++; end
    check("tmo_latency", n - 1, 10);
    check("tmo_idle", active, 0);
    hold_busy = 0;
    repeat (6) @(negedge clk);
    check("tmo_no_done", done_cnt, 0);
    clear_logs();
    pulse_start(21'h000600, 21'd1);
    @(negedge clk);
    check("tmo_error_cleared", error, 0);
    check("tmo_restart_active", active, 1);
    wait_done();
    check_stream("tmo_restart", 21'h000600, 1);
`else
    repeat (30) @(negedge clk);
    check("hold_no_error", error, 0);
    check("hold_active", active, 1);
    @(posedge clk); #1 abort = 1; hold_busy = 0;
    @(posedge clk); #1 abort = 0;
    n = 0;
    while (active && n < 50) begin @(negedge clk); n++; end
    check("hold_abort_idle", active, 0);
    check("hold_no_done", done_cnt, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      case ($urandom % 3)
        0: ra = 21'h1FFFFF - 21'($urandom_range(0, 5));
        1: ra = 21'h0FFFFF - 21'($urandom_range(0, 5));
        default: ra = 21'($urandom);
      endcase
      rn = 21'($urandom_range(1, 12));
      run_xfer($sformatf("rnd%0d", i), ra, rn, $urandom_range(0, 2), $urandom_range(1, 4),
               $urandom_range(0, 2), 21'((longint'(ra) + rn - 1) % 2097152));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
